// File: rtl/vecmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vecmem_pkg
// Description : Shared types and constants for the vector-add memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
package vecmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned c_REGION_A_OFFSET    = 32'd0;
  localparam int unsigned c_REGION_B_OFFSET    = 32'd32768;
  localparam int unsigned c_REGION_C_OFFSET    = 32'd65536;
  localparam int          c_ADDR_SHIFT_DEFAULT = 5;

endpackage
`default_nettype wire

// File: rtl/vecmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : vecmem_ram
// Description : Single-port word store, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module vecmem_ram
  import vecmem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int WD    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [WD-1:0] i_d,
  output logic [WD-1:0] o_q
);

  logic [WD-1:0] r_mem [DEPTH];
  logic [WD-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_d;
    end
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/vecmem_slave.sv
`default_nettype none
// ============================================================================
// Module      : vecmem_slave
// Description : MEM_* handshake responder with fixed latency, counters, error.
// Revision    : 1.0 - initial release
// ============================================================================
module vecmem_slave
  import vecmem_pkg::*;
#(
  parameter int WA         = 32,
  parameter int WD         = 32,
  parameter int ADDR_SHIFT = c_ADDR_SHIFT_DEFAULT,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 4
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [WA-1:0] MEM_A,
  input  logic          MEM_RE,
  input  logic          MEM_WE,
  input  logic [WD-1:0] MEM_D,
  output logic [WD-1:0] MEM_Q,
  output logic          MEM_BUSY,
  output logic          MEM_DONE,
  output logic          ERR,
  output logic [31:0]   RD_CNT,
  output logic [31:0]   WR_CNT
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic          r_is_wr;
  logic          r_oob;
  logic          r_q_zero;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [WD-1:0] r_d;
  logic [31:0]   r_rd_cnt;
  logic [31:0]   r_wr_cnt;
  logic [WD-1:0] w_ram_q;
  logic [WA-1:0] w_idx;
  logic          w_req;
  logic          w_accept;
  logic          w_in_range;
  logic          w_commit;

  assign w_req      = MEM_RE | MEM_WE;
  assign w_accept   = (r_state == ST_IDLE) && w_req;
  assign w_idx      = MEM_A >> ADDR_SHIFT;
  assign w_in_range = (w_idx < WA'(DEPTH));
  // The edge that enters RESP is the one that touches the store.
  assign w_commit   = (r_state == ST_WAIT) && (r_cnt == 4'd1);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_cnt    <= '0;
      r_is_wr  <= 1'b0;
      r_oob    <= 1'b0;
      r_idx    <= '0;
      r_d      <= '0;
      r_err    <= 1'b0;
      r_q_zero <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_LAT_LOAD;
        r_is_wr <= MEM_WE;
        r_oob   <= !w_in_range;
        r_idx   <= w_idx[AW-1:0];
        r_d     <= MEM_D;
        if ((MEM_RE && MEM_WE) || !w_in_range) begin
          r_err <= 1'b1;
        end
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        if (r_is_wr) begin
          r_wr_cnt <= r_wr_cnt + 32'd1;
        end else begin
          r_rd_cnt <= r_rd_cnt + 32'd1;
          r_q_zero <= r_oob;
        end
      end
    end
  end

  vecmem_ram #(
    .DEPTH (DEPTH),
    .WD    (WD),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_rst_n (RST_X),
    .i_we    (w_commit && r_is_wr && !r_oob),
    .i_re    (w_commit && !r_is_wr && !r_oob),
    .i_addr  (r_idx),
    .i_d     (r_d),
    .o_q     (w_ram_q)
  );

  // An out-of-range read leaves the RAM register alone and masks it to zero.
  assign MEM_Q    = r_q_zero ? '0 : w_ram_q;
  assign MEM_BUSY = (r_state != ST_IDLE);
  assign MEM_DONE = (r_state == ST_RESP);
  assign ERR      = r_err;
  assign RD_CNT   = r_rd_cnt;
  assign WR_CNT   = r_wr_cnt;

endmodule
`default_nettype wire
